// File: rtl/bs_gnrtr_n_rbtr.sv
// -----------------------------------------------------------------------------
// bs_gnrtr_n_rbtr -- single-bus packet generator/arbiter.
//
// Devices present packets through source FIFOs. A two-state FSM grants one
// pending source at a time using round-robin arbitration. It pops the head word
// and delivers it on the shared bus on the following cycle. The top byte of each
// packet is the destination ID. The broadcast ID reaches every device except
// the sender. IDs at or above drvrs (other than broadcast) are dropped.
//
// Ports:
//   clk     - clock, all state updates on the rising edge
//   reset   - asynchronous active-high reset
//   pndng   - per-device "source FIFO non-empty"
//   D_pop   - per-device FIFO head word
//   pop     - one-cycle pulse consuming the granted device's head word
//   push    - one-cycle pulse per receiving device
//   D_push  - delivered packet, same word on every device lane
// -----------------------------------------------------------------------------
module bs_gnrtr_n_rbtr #(
    parameter int unsigned bits      = 1,
    parameter int unsigned drvrs     = 4,
    parameter int unsigned pckg_sz   = 16,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [bits-1:0][drvrs-1:0]             pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
    output logic [bits-1:0][drvrs-1:0]             pop,
    output logic [bits-1:0][drvrs-1:0]             push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);

    localparam int unsigned IW = (drvrs > 1) ? $clog2(drvrs) : 1;

    typedef enum logic {IDLE, DELIVER} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        src_q, src_d;
    logic [pckg_sz-1:0]   pkt_q, pkt_d;

    logic                 grant_vld;
    logic [IW-1:0]        grant_idx;
    logic [IW-1:0]        cand;
    logic [drvrs-1:0]     pop_vec;
    logic [drvrs-1:0]     push_vec;
    logic [7:0]           dst;
    logic                 is_bcast;

    // (base + off) mod drvrs; both operands are below drvrs so one subtract suffices.
    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int unsigned off);
        logic [IW:0] s;
        s = {1'b0, base} + (IW+1)'(off);
        if (s >= (IW+1)'(drvrs)) begin
            s = s - (IW+1)'(drvrs);
        end
        return s[IW-1:0];
    endfunction

    // Round-robin search: first pending device at or after the pointer, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < drvrs; k++) begin
            cand = rr_idx(ptr_q, k);
            if (!grant_vld && pndng[0][cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        pkt_d   = pkt_q;
        pop_vec = '0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    pop_vec[grant_idx] = 1'b1;
                    src_d              = grant_idx;
                    pkt_d              = D_pop[0][grant_idx];
                    ptr_d              = (grant_idx == IW'(drvrs - 1)) ? '0 : grant_idx + 1'b1;
                    state_d            = DELIVER;
                end
            end
            DELIVER: begin
                // Delivery always completes in one cycle, dropped packets included.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            src_q   <= '0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            pkt_q   <= pkt_d;
        end
    end

    assign dst      = pkt_q[pckg_sz-1 -: 8];
    assign is_bcast = (dst == broadcast);

    // A destination of drvrs or above matches no lane, so invalid IDs fall out
    // as "no push" without a separate drop path.
    for (genvar gi = 0; gi < drvrs; gi++) begin : g_lane
        assign push_vec[gi]  = (state_q == DELIVER) &&
                               (is_bcast ? (src_q != IW'(gi)) : (dst == 8'(gi)));
        assign D_push[0][gi] = pkt_q;
    end

    // pop is combinational from pndng, so it must be masked while reset is
    // held (the state register already sits in IDLE during reset).
    assign pop[0]  = reset ? '0 : pop_vec;
    assign push[0] = push_vec;

    // Only bus 0 is serviced; any further bus slots are tied off.
    for (genvar gb = 1; gb < bits; gb++) begin : g_unused_bus
        assign pop[gb]    = '0;
        assign push[gb]   = '0;
        assign D_push[gb] = '0;
    end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
module tb_bs_gnrtr_n_rbtr;

    localparam int ND = 5;
    localparam int PW = 16;

    logic                         clk   = 1'b0;
    logic                         reset = 1'b1;
    logic [0:0][ND-1:0]           pndng;
    logic [0:0][ND-1:0][PW-1:0]   D_pop;
    logic [0:0][ND-1:0]           pop;
    logic [0:0][ND-1:0]           push;
    logic [0:0][ND-1:0][PW-1:0]   D_push;

    always #5 clk = ~clk;

    bs_gnrtr_n_rbtr #(
        .bits      (1),
        .drvrs     (ND),
        .pckg_sz   (PW),
        .broadcast (8'hFF)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pndng  (pndng),
        .D_pop  (D_pop),
        .pop    (pop),
        .push   (push),
        .D_push (D_push)
    );

    typedef struct packed {
        int unsigned cyc;
        logic [2:0]  src;
    } pop_exp_t;

    typedef struct packed {
        int unsigned   cyc;
        logic [ND-1:0] mask;
        logic [PW-1:0] data;
    } push_exp_t;

    int              checks = 0;
    int              errors = 0;
    int unsigned     cyc    = 0;

    logic [PW-1:0]   fifo [ND][$];
    pop_exp_t        exp_pop[$];
    push_exp_t       exp_push[$];

    // reference model state
    int              m_ptr     = 0;
    bit              m_deliver = 0;

    // monitor state
    logic [ND-1:0]   last_pop  = '0;
    logic [PW-1:0]   mon_dpush = '0;
    logic [ND-1:0]   mon_ep;
    logic [ND-1:0]   mon_em;
    int              grant_log[$];
    logic [ND+PW-1:0] push_log[$];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic drive_fifos();
        for (int i = 0; i < ND; i++) begin
            pndng[0][i] = (fifo[i].size() != 0);
            D_pop[0][i] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
        end
    endtask

    // Receivers of a packet from src, derived from the destination-ID rules.
    function automatic logic [ND-1:0] dest_mask(input int src, input logic [PW-1:0] pkt);
        logic [7:0]    d;
        logic [ND-1:0] m;
        d = pkt[PW-1 -: 8];
        m = '0;
        if (d == 8'hFF) begin
            m      = '1;
            m[src] = 1'b0;
        end else if (int'(d) < ND) begin
            m[d] = 1'b1;
        end
        return m;
    endfunction

    // Behavioural model: one grant per two cycles, round-robin over non-empty
    // FIFOs, delivery on the following cycle.
    task automatic model_step();
        pop_exp_t  pe;
        push_exp_t qe;
        int        s;
        if (reset) return;
        if (m_deliver) begin
            m_deliver = 0;
            return;
        end
        for (int k = 0; k < ND; k++) begin
            s = (m_ptr + k) % ND;
            if (fifo[s].size() != 0) begin
                pe.cyc  = cyc;
                pe.src  = 3'(s);
                exp_pop.push_back(pe);
                qe.cyc  = cyc + 1;
                qe.mask = dest_mask(s, fifo[s][0]);
                qe.data = fifo[s][0];
                exp_push.push_back(qe);
                m_ptr     = (s + 1) % ND;
                m_deliver = 1;
                break;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < ND; i++) begin
            if (last_pop[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
        end
        cyc++;
        drive_fifos();
        model_step();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic set_reset(input bit v);
        reset = v;
        if (v) begin
            exp_pop.delete();
            exp_push.delete();
            m_ptr     = 0;
            m_deliver = 0;
        end else begin
            model_step();
        end
    endtask

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                check("reset_outputs", {pop[0], push[0], D_push[0]}, '0);
                last_pop  = '0;
                mon_dpush = '0;
            end else begin
                while (exp_pop.size() != 0 && exp_pop[0].cyc < cyc) begin
                    checks++; errors++;
                    $display("FAIL pop_missed cyc=%0d actual=none required=src%0d", cyc, exp_pop[0].src);
                    void'(exp_pop.pop_front());
                end
                while (exp_push.size() != 0 && exp_push[0].cyc < cyc) begin
                    checks++; errors++;
                    $display("FAIL push_missed cyc=%0d actual=none required=%0h", cyc, exp_push[0].mask);
                    void'(exp_push.pop_front());
                end
                mon_ep = '0;
                if (exp_pop.size() != 0 && exp_pop[0].cyc == cyc) begin
                    mon_ep[exp_pop[0].src] = 1'b1;
                    void'(exp_pop.pop_front());
                end
                check("pop", pop[0], mon_ep);
                mon_em = '0;
                if (exp_push.size() != 0 && exp_push[0].cyc == cyc) begin
                    mon_em    = exp_push[0].mask;
                    mon_dpush = exp_push[0].data;
                    void'(exp_push.pop_front());
                end
                check("push", push[0], mon_em);
                check("d_push", D_push[0], {ND{mon_dpush}});
                for (int i = 0; i < ND; i++) begin
                    if (pop[0][i]) grant_log.push_back(i);
                end
                if (push[0] != '0) push_log.push_back({push[0], D_push[0][0]});
                last_pop = pop[0];
            end
        end
    end

    // Stimulus
    initial begin
        int g;
        int exp_order[6];
        logic [PW-1:0] pkt;
        logic [7:0]    d;
        exp_order = '{0, 1, 2, 3, 4, 0};
        reset = 1'b1;
        drive_fifos();
        run(3);
        set_reset(0);
        run(2);

        // unicast 1 -> 2
        push_log.delete();
        fifo[1].push_back(16'h0208);
        run(4);
        check("unicast_count", push_log.size(), 1);
        if (push_log.size() != 0) check("unicast_push", push_log[0], {5'b00100, 16'h0208});

        // broadcast from 3
        push_log.delete();
        fifo[3].push_back(16'hFF55);
        run(4);
        check("bcast_count", push_log.size(), 1);
        if (push_log.size() != 0) check("bcast_push", push_log[0], {5'b10111, 16'hFF55});

        // invalid destination from 0
        push_log.delete();
        grant_log.delete();
        fifo[0].push_back(16'h0711);
        run(4);
        check("invalid_no_push", push_log.size(), 0);
        check("invalid_popped", grant_log.size(), 1);

        // all-to-one
        push_log.delete();
        for (int s = 0; s < 4; s++) fifo[s].push_back({8'h04, 8'(8'hA0 + s)});
        run(10);
        check("all_to_one_count", push_log.size(), 4);

        // contention from reset: all five pending
        set_reset(1);
        for (int s = 0; s < ND; s++) begin
            fifo[s].push_back({8'(s), 8'h10});
            fifo[s].push_back({8'(s), 8'h20});
        end
        run(2);
        grant_log.delete();
        set_reset(0);
        run(14);
        check("contention_count", grant_log.size() >= 6, 1);
        for (int i = 0; i < 6; i++) begin
            if (grant_log.size() > i) check("contention_grant", grant_log[i], exp_order[i]);
        end
        run(10);

        // reset during DELIVER
        fifo[2].push_back(16'h0312);
        g = 0;
        do begin cycle(); g++; end while (!m_deliver && g < 10);
        check("mid_reset_grant_seen", m_deliver, 1);
        cycle();
        set_reset(1);
        run(2);
        push_log.delete();
        set_reset(0);
        run(3);
        check("mid_reset_lost", push_log.size(), 0);
        fifo[4].push_back(16'h0033);
        run(4);
        check("resume_count", push_log.size(), 1);
        if (push_log.size() != 0) check("resume_push", push_log[0], {5'b00001, 16'h0033});

        // randomized traffic
        repeat (400) begin
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: d = 8'($urandom_range(0, ND - 1));
                    6, 7:             d = 8'hFF;
                    default:          d = 8'($urandom_range(ND, 254));
                endcase
                pkt = {d, 8'($urandom)};
                fifo[$urandom_range(0, ND - 1)].push_back(pkt);
            end
            cycle();
        end

        // drain
        g = 0;
        while (g < 2000 && (m_deliver || fifo[0].size() != 0 || fifo[1].size() != 0 ||
               fifo[2].size() != 0 || fifo[3].size() != 0 || fifo[4].size() != 0)) begin
            cycle();
            g++;
        end
        check("drain_in_time", g < 2000, 1);
        run(3);
        check("scoreboard_empty", exp_pop.size() + exp_push.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bs_gnrtr_n_rbtr.md
BS_GNRTR_N_RBTR -- requirements
Module: bs_gnrtr_n_rbtr

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- bits, 1, number of buses (fixed 1; leading array dimension)
- drvrs, 4, number of attached devices
- pckg_sz, 16, packet width in bits
- broadcast, 8'hFF, destination ID meaning "all devices"
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on rising edge
- reset, in, 1, asynchronous active-high reset
- pndng, in, [bits-1:0][drvrs-1:0], device i source FIFO non-empty
- D_pop, in, [bits-1:0][drvrs-1:0][pckg_sz-1:0], device i FIFO head word, valid while pndng[0][i]=1
- pop, out, [bits-1:0][drvrs-1:0], one-cycle pulse consuming device i head word
- push, out, [bits-1:0][drvrs-1:0], one-cycle pulse delivering D_push[0][j] to device j
- D_push, out, [bits-1:0][drvrs-1:0][pckg_sz-1:0], delivered packet, same word driven to every j
REQ-003 Reset SHALL be asynchronous and active-high, on port reset; clock is clk.

Function
REQ-004 Packet format SHALL be [pckg_sz-1:pckg_sz-8] = destination ID, [pckg_sz-9:0] = payload; packets forwarded unmodified.
REQ-005 FSM SHALL have states IDLE, DELIVER.
REQ-006 IDLE: if any pndng[0][i]=1, grant one source, pulse pop[0][src] that cycle, capture D_pop[0][src] and src, go DELIVER; else stay IDLE, all pop=0.
REQ-007 Arbitration SHALL be round-robin: search starts at (last granted + 1) mod drvrs, lowest index at/after pointer wins; pointer = 0 after reset.
REQ-008 DELIVER: drive captured packet on all D_push[0][j]; pulse push for one cycle, return IDLE next cycle.
REQ-009 Destination ID = broadcast: push[0][j]=1 for every j != src.
REQ-010 Destination ID < drvrs (non-broadcast): push[0][dst]=1 only, including dst == src.
REQ-011 Destination ID >= drvrs and != broadcast: packet dropped, no push, still return IDLE.
REQ-012 Latency: pop at cycle N, push at cycle N+1; next grant no earlier than N+2; max one packet per 2 cycles.
REQ-013 pop SHALL never be asserted for a device with pndng=0; at most one pop bit high per cycle.
REQ-014 pndng changing during DELIVER SHALL not affect the in-flight packet.
REQ-015 D_push SHALL hold last captured packet between transfers.

Reset
REQ-016 While reset=1: pop=0, push=0, D_push=0, state IDLE, RR pointer 0, captured packet/src cleared.
REQ-017 Reset asserted mid-transfer SHALL abort it immediately; packet popped but not pushed is lost; no push after reset release until a new grant.
REQ-018 First grant possible on first rising clk edge after reset deasserts.

Verification (drvrs=5, pckg_sz=16, broadcast=8'hFF)
REQ-019 Unicast: pndng[0][1]=1, D_pop[0][1]=16'h0208 -> pop[0][1] pulse cycle N; push[0][2] pulse cycle N+1 with D_push=16'h0208; no other push.
REQ-020 Broadcast: source 3 sends 16'hFF55 -> push[0][0,1,2,4]=1 together one cycle, push[0][3]=0, D_push=16'hFF55.
REQ-021 Contention: pndng[0][0..4] all held 1 after reset -> pops granted in order 0,1,2,3,4,0 at 2-cycle spacing.
REQ-022 Invalid destination: source 0 sends 16'h0711 -> pop[0][0] pulse, no push asserted, FSM back to IDLE.
REQ-023 Reset mid-transfer: assert reset in DELIVER cycle -> push stays 0, all outputs 0 during reset, normal service resumes after release.
REQ-024 All-to-one: sources 0,1,2,3 each send to ID 4 -> four push[0][4] pulses, payloads in round-robin order, none lost.
